// File: rtl/serial_fad_adder.sv
// Bit-serial WIDTH-bit adder: operands are fed LSB-first through a single
// full-adder cell, with its carry registered and fed back each clock.

module fad_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_fad_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADD,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opa_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-2:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic               cell_sum;
    logic               cell_cout;
    logic [WIDTH-1:0]   acc_shift;

    fad_cell u_cell (
        .a    (opa_q[0]),
        .b    (opb_q[0]),
        .cin  (carry_q),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    // The accumulator holds only WIDTH-1 bits: the final cell bit completes
    // the result on the same edge it is produced.
    assign acc_shift = {cell_sum, acc_q};

    always_comb begin
        // NOTE: every signal gets a hold default first so no path infers a latch.
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_ADD;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADD: begin
                acc_d   = acc_shift[WIDTH-1:1];
                carry_d = cell_cout;
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = acc_shift;
                    cout_d  = cell_cout;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == ST_ADD);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_fad_adder.sv
// Self-checking bench for serial_fad_adder: directed cases plus a random sweep
// against a plain-arithmetic model of {cout,sum} = a + b + cin.

module tb_serial_fad_adder;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_checks = 0;
    int n_errors = 0;

    // Result the DUT should be holding on sum/cout while no new result has completed.
    logic [W-1:0] held_sum  = '0;
    logic         held_cout = 1'b0;

    serial_fad_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT in IDLE or DONE. Returns at the negedge
    // of the DONE cycle (or after the time-out), with start low.
    task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                           input int glitch_at, input string tag);
        int unsigned total;
        int          edges;
        int          busy_cycles;
        bit          hold_ok;
        total = int'(ta) + int'(tbv) + int'(tc);
        a = ta; b = tbv; cin = tc; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
        edges = 0;
        busy_cycles = 0;
        hold_ok = 1'b1;
        while (!done && edges < 40) begin
            if (busy) busy_cycles++;
            if (sum !== held_sum || cout !== held_cout) hold_ok = 1'b0;
            start = (edges == glitch_at);
            if (edges == glitch_at) a = '1;
            @(negedge clk);
            start = 1'b0;
            edges++;
        end
        check({tag, "_latency"}, 32'(edges), 32'(W));
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(W));
        check({tag, "_hold"}, 32'(hold_ok), 32'd1);
        check({tag, "_sum"}, 32'(sum), 32'(total % (1 << W)));
        check({tag, "_cout"}, 32'(cout), 32'((total >> W) & 1));
        held_sum  = W'(total % (1 << W));
        held_cout = 1'((total >> W) & 1);
    endtask

    // After a completed add with no new start: done must drop and the block idle.
    task automatic check_pulse_end(input string tag);
        @(negedge clk);
        check({tag, "_done_width"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int dones;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        @(negedge clk);

        run_add(8'h0F, 8'h01, 1'b0, -1, "t0f_01");
        check_pulse_end("t0f_01");
        run_add(8'hFF, 8'h01, 1'b0, -1, "tff_01");
        check_pulse_end("tff_01");
        run_add(8'hFF, 8'hFF, 1'b1, -1, "tff_ff_c");
        check_pulse_end("tff_ff_c");
        run_add(8'h00, 8'h00, 1'b0, -1, "tzero");
        check_pulse_end("tzero");

        // A start pulse during ADD (with a different operand) must be ignored.
        run_add(8'h12, 8'h34, 1'b0, 3, "tignore");
        check_pulse_end("tignore");

        // Start during the DONE cycle begins the next addition at once.
        run_add(8'h55, 8'h22, 1'b1, -1, "tb2b_first");
        run_add(8'h80, 8'h80, 1'b0, -1, "tb2b_second");
        check_pulse_end("tb2b_second");

        // Reset in the middle of an addition aborts it.
        a = 8'h3C; b = 8'h41; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        held_sum = '0;
        held_cout = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_add(8'hA7, 8'h6B, 1'b0, -1, "after_abort");
        check_pulse_end("after_abort");

        // Random sweep, mixing back-to-back starts and idle gaps.
        for (int i = 0; i < 60; i++) begin
            run_add(W'($urandom), W'($urandom), 1'($urandom), -1, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 2) == 0) begin
                check_pulse_end($sformatf("rnd%0d", i));
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
